// File: rtl/zneg_pkg.sv
// Shared helpers for the z^-D delay line: delay clamping, modular pointer math, defaults.
package zneg_pkg;

  localparam int unsigned DefaultBitwidth = 32;

  // Maps a requested delay onto the supported range 1..max_delay.
  function automatic int unsigned delay_clamp(input int unsigned delay,
                                              input int unsigned max_delay);
    if (delay == 0) begin
      return 1;
    end else if (delay > max_delay) begin
      return max_delay;
    end
    return delay;
  endfunction

  // (a - b) mod m for a < m and b < m, with no power-of-two assumption.
  function automatic int unsigned ptr_sub_mod(input int unsigned a, input int unsigned b,
                                              input int unsigned m);
    if (a >= b) begin
      return a - b;
    end
    return a + m - b;
  endfunction

endpackage

// File: rtl/zneg_n_ram.sv
// Sample buffer for zneg_n: one synchronous write port, one asynchronous read port.
module zneg_n_ram
  import zneg_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = DefaultBitwidth,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read sees the old word on a same-cycle write to the same address.
  assign rdata = mem[raddr];

endmodule

// File: rtl/zneg_n.sv
// Run-time selectable z^-D delay line advancing on a sample strobe.
// Optional macro ZNEG_N_PRIME_EN adds fill tracking and zeroes output until primed.
module zneg_n
  import zneg_pkg::*;
#(
  parameter int unsigned BITWIDTH  = DefaultBitwidth,
  parameter int unsigned MAX_DELAY = 64,
  parameter int unsigned DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DW-1:0]       delay,
  input  logic [BITWIDTH-1:0] sig_in,
  output logic [BITWIDTH-1:0] sig_out,
  output logic                out_valid,
  output logic                delay_clamped
);

  localparam int unsigned AW = $clog2(MAX_DELAY);

  logic [AW-1:0]       wp_q, wp_d, rd_addr;
  logic [BITWIDTH-1:0] rd_data, out_d, sig_out_q;
  logic                out_valid_q, clamped_q, clamped_d;
  int unsigned         de;

  always_comb begin
    de        = delay_clamp(32'(delay), MAX_DELAY);
    rd_addr   = AW'(ptr_sub_mod(32'(wp_q), de - 1, MAX_DELAY));
    wp_d      = (wp_q == AW'(MAX_DELAY - 1)) ? '0 : wp_q + 1'b1;
    out_d     = (de == 1) ? sig_in : rd_data;
    clamped_d = (delay == '0) || (32'(delay) > MAX_DELAY);
  end

  zneg_n_ram #(
    .DEPTH (MAX_DELAY),
    .WIDTH (BITWIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (en && !rst),
    .waddr (wp_q),
    .wdata (sig_in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef ZNEG_N_PRIME_EN
  logic [DW-1:0] fill_q, fill_d;
  logic          valid_d;

  always_comb begin
    valid_d = (32'(fill_q) + 1) >= de;
    fill_d  = (32'(fill_q) == MAX_DELAY) ? fill_q : fill_q + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_out_q   <= '0;
      out_valid_q <= 1'b0;
      clamped_q   <= 1'b0;
      wp_q        <= '0;
`ifdef ZNEG_N_PRIME_EN
      fill_q      <= '0;
`endif
    end else begin
      clamped_q <= clamped_d;
`ifdef ZNEG_N_PRIME_EN
      if (en) begin
        wp_q        <= wp_d;
        fill_q      <= fill_d;
        out_valid_q <= valid_d;
        sig_out_q   <= valid_d ? out_d : '0;
      end
`else
      out_valid_q <= 1'b1;
      if (en) begin
        wp_q      <= wp_d;
        sig_out_q <= out_d;
      end
`endif
    end
  end

  assign sig_out       = sig_out_q;
  assign out_valid     = out_valid_q;
  assign delay_clamped = clamped_q;

endmodule

// File: doc/zneg_n.md
# zneg_n

Parametrised multi-sample delay line z^-D for the DSP datapath. It generalises the single-register unit delay into a circular buffer holding up to MAX_DELAY samples. The delay D is selectable at run time, and samples advance only on a sample-enable strobe, so the block works at audio sample rates inside a faster system clock domain. With D=1 and en tied high it is cycle-identical to the unit delay, so existing filter sections migrate without retiming.

## Interface
- BITWIDTH, 32, sample width in bits
- MAX_DELAY, 64, largest supported delay in samples; must be ≥ 2; need not be a power of two
- DW, $clog2(MAX_DELAY+1), width of delay port (derived; not overridden)

- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk
- en  in  1  sample strobe; one accepted sample per high cycle
- delay  in  DW  requested delay D in samples; legal range 1..MAX_DELAY
- sig_in  in  BITWIDTH  input sample x[n]
- sig_out  out  BITWIDTH  delayed sample, registered
- out_valid  out  1  buffer holds at least D accepted samples
- delay_clamped  out  1  current delay input is out of range, registered

## Operation
- Effective delay De:
  - delay==0 → De=1.
  - delay>MAX_DELAY → De=MAX_DELAY.
  - Otherwise De=delay.
- delay_clamped <= (delay==0 || delay>MAX_DELAY) on every clk edge, independent of en.
- Storage: MAX_DELAY-entry array plus write pointer wp in 0..MAX_DELAY-1.
- On an en edge (accepted sample n):
  - mem[wp] <= sig_in.
  - wp <= (wp==MAX_DELAY-1) ? 0 : wp+1. Wrap is explicit; no power-of-two masking.
  - sig_out <= x[n-De+1]:
    - De==1: the value is sig_in (bypass).
    - Otherwise: read mem[(wp-(De-1)) mod MAX_DELAY] before the write.
  - fill_cnt <= min(fill_cnt+1, MAX_DELAY).
  - out_valid <= (fill_cnt+1 ≥ De).
- When en is low: sig_out, wp, fill_cnt and out_valid hold. delay_clamped still updates.
- Delay changes take effect at the next en edge.
  - Buffer contents are kept; fill_cnt is not cleared.
  - Shortening the delay keeps out_valid high.
  - Lengthening it beyond fill_cnt drops out_valid until enough samples have been accepted.
- Reset:
  - sig_out=0, out_valid=0, delay_clamped=0, wp=0, fill_cnt=0.
  - Memory is not cleared.
  - rst has priority over a simultaneous en; that sample is discarded.

## Timing
- Latency: one clk from the en edge to sig_out update; De-1 further accepted samples of history.
- Delay is counted in accepted samples (en strobes), not in clocks.
- D=1, en=1 every cycle: sig_out(k+1) = sig_in(k). This is the unit-delay equivalence.
- The read is asynchronous from the array and the output is registered, so there is no extra pipeline stage.
- Reset asserted mid-stream: outputs are zero the clk after rst is sampled; refill starts from the first en after rst deasserts.

## Configuration
- ZNEG_N_PRIME_EN defined:
  - fill_cnt and out_valid are implemented as above.
  - sig_out is forced to 0 on any en edge where the new out_valid is 0, so no stale or unknown memory reaches the output.
- ZNEG_N_PRIME_EN undefined:
  - fill_cnt is removed.
  - out_valid is 0 in reset and 1 from the first cycle after rst deasserts.
  - sig_out presents raw buffer contents, which are unknown until primed.

## Structure
- Shared package zneg_pkg:
  - delay_clamp function (delay, MAX_DELAY → De).
  - ptr_sub_mod function for modular pointer subtraction.
  - Constant for the default BITWIDTH.
- Sub-module zneg_n_ram:
  - MAX_DELAY x BITWIDTH array.
  - One synchronous write port, one asynchronous read port.
  - Read-before-write on address collision.
- Top level zneg_n holds wp, fill_cnt, bypass mux, output register and the prime mask.

## Test plan
- D=1, en=1 constant, sig_in ramp 1,2,3,…:
  - sig_out equals sig_in one clk later: 1,2,3,….
  - out_valid=1 after the first edge.
- D=5, en=1, ramp from 10, macro on:
  - sig_out reads 0,0,0,0,10,11,12,….
  - out_valid rises on the 5th accepted sample.
- D=3, en high every 3rd clk, ramp from 1:
  - sig_out holds between strobes.
  - Strobe outputs: 0,0,1,2,3,….
- MAX_DELAY=8, D=8, 20-sample ramp from 1:
  - Output from the 8th accepted sample is 1,2,…,13, correct across two pointer wraps.
  - D=9: output matches D=8 and delay_clamped=1 one clk later.
  - D=0: output matches D=1 and delay_clamped=1.
- Delay change, ramp from 1:
  - D 6→2 after 10 samples: next outputs are 10,11; out_valid stays 1.
  - Reset, then D=2 for 4 samples, then D=6: out_valid falls, and returns on the 6th accepted sample.
- rst asserted mid-stream with en=1:
  - Next clk: sig_out=0 and out_valid=0; the simultaneous sample is discarded.
  - After rst deasserts, refill matches the scenario-2 sequence.
